// File: rtl/regbank16_if.sv
// Write-port and bit-sliced read-side bundle for the 16-entry register bank.
// The master drives the write strobe; the slave presents storage contents and status.
interface regbank16_if #(
    parameter int WIDTH = 64
);
    logic                  wr_en;
    logic [3:0]            wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic [16*WIDTH-1:0]   rd_slices;
    logic [15:0]           written;
    logic                  wr_drop;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  rd_slices, written, wr_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output rd_slices, written, wr_drop
    );
endinterface

// File: rtl/regbank16.sv
// 16 x WIDTH register storage with one synchronous write port, outputs bit-sliced
// so each per-bit mux16_1 read tree sees one contiguous 16-bit group.
module regbank16 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    regbank16_if.slave   bus
);
    logic [WIDTH-1:0]    regs_q [16];
    logic [WIDTH-1:0]    regs_d [16];
    logic [15:0]         written_q;
    logic [15:0]         written_d;
    logic                wr_drop_q;
    logic                wr_drop_d;
    logic [15:0]         wr_sel;
    logic [16*WIDTH-1:0] slices;

    // The ZERO_REG enable is forced low, so its storage and written bit never leave 0.
    always_comb begin
        wr_sel = '0;
        if (bus.wr_en) begin
            wr_sel[bus.wr_addr] = 1'b1;
        end
        wr_sel[ZERO_REG] = 1'b0;
        wr_drop_d = bus.wr_en && (bus.wr_addr == 4'(ZERO_REG));
        written_d = written_q | wr_sel;
        for (int r = 0; r < 16; r++) begin
            regs_d[r] = wr_sel[r] ? bus.wr_data : regs_q[r];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 16; r++) begin
                regs_q[r] <= '0;
            end
            written_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                regs_q[r] <= regs_d[r];
            end
            written_q <= written_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Bit b of register r lands at b*16 + r: register 0 is the LSB of each group.
    always_comb begin
        slices = '0;
        for (int b = 0; b < WIDTH; b++) begin
            for (int r = 0; r < 16; r++) begin
                slices[b*16 + r] = regs_q[r][b];
            end
        end
    end

    assign bus.rd_slices = slices;
    assign bus.written   = written_q;
    assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_regbank16.sv
// Directed bench for regbank16: a per-register array model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_regbank16;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    regbank16_if #(.WIDTH(W)) bus ();

    regbank16 #(.WIDTH(W), .ZERO_REG(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain register file, sticky written mask, drop flag.
    logic [W-1:0] mreg [16];
    logic [15:0]  mwr = '0;
    logic         mdrop = 1'b0;

    initial begin
        for (int r = 0; r < 16; r++) mreg[r] = '0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 16; r++) mreg[r] = '0;
            mwr = '0;
            mdrop = 1'b0;
        end else if (bus.wr_en === 1'b1) begin
            if (bus.wr_addr == 4'd15) begin
                mdrop = 1'b1;
            end else begin
                mreg[bus.wr_addr] = bus.wr_data;
                mwr[bus.wr_addr] = 1'b1;
                mdrop = 1'b0;
            end
        end else begin
            mdrop = 1'b0;
        end
    end

    // What a mux16_1 with sel=r returns for every bit group.
    function automatic logic [W-1:0] read_reg(input logic [16*W-1:0] s, input int r);
        logic [W-1:0] v;
        logic [15:0]  grp;
        for (int b = 0; b < W; b++) begin
            grp = s[b*16 +: 16];
            v[b] = grp[r];
        end
        return v;
    endfunction

    task automatic check64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < 16; r++) begin
                check64($sformatf("model reg%0d", r), read_reg(bus.rd_slices, r), mreg[r]);
            end
            check16("model written", bus.written, mwr);
            check16("model wr_drop", {15'd0, bus.wr_drop}, {15'd0, mdrop});
        end
    end

    always @(posedge clk) begin
        if (reset_n && bus.wr_en === 1'b1 && $isunknown(bus.wr_addr)) begin
            bad++;
            $display("FAIL wr_addr_x: got %b expected known value", bus.wr_addr);
        end
    end

    // Drive one cycle's inputs shortly after the rising edge.
    task automatic cyc(input logic en, input logic [3:0] addr, input logic [W-1:0] data);
        @(posedge clk);
        #2;
        bus.wr_en = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] pat;
        logic [3:0]   r4;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        #3;
        check16("por written", bus.written, 16'h0000);
        check64("por slices lo", bus.rd_slices[63:0], 64'h0);
        check16("por wr_drop", {15'd0, bus.wr_drop}, 16'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;

        // basic write
        cyc(1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567);
        cyc(1'b0, 4'd0, '0);
        check64("basic reg3", read_reg(bus.rd_slices, 3), 64'hDEAD_BEEF_0123_4567);
        check16("basic written", bus.written, 16'h0008);
        check64("basic reg2", read_reg(bus.rd_slices, 2), 64'h0);
        check64("basic reg4", read_reg(bus.rd_slices, 4), 64'h0);

        // zero register
        cyc(1'b1, 4'd15, {W{1'b1}});
        cyc(1'b0, 4'd0, '0);
        check16("zero wr_drop hi", {15'd0, bus.wr_drop}, 16'h1);
        check64("zero reg15", read_reg(bus.rd_slices, 15), 64'h0);
        check16("zero written", bus.written, 16'h0008);
        cyc(1'b0, 4'd0, '0);
        check16("zero wr_drop lo", {15'd0, bus.wr_drop}, 16'h0);

        // back-to-back overwrite
        cyc(1'b1, 4'd7, 64'h1);
        cyc(1'b1, 4'd7, 64'h2);
        check64("ovw first", read_reg(bus.rd_slices, 7), 64'h1);
        cyc(1'b0, 4'd0, '0);
        check64("ovw reg7", read_reg(bus.rd_slices, 7), 64'h2);
        check16("ovw written", bus.written, 16'h0088);

        // asynchronous reset mid-cycle, no edge in between
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check16("async written", bus.written, 16'h0000);
        check64("async reg3", read_reg(bus.rd_slices, 3), 64'h0);
        check64("async reg7", read_reg(bus.rd_slices, 7), 64'h0);
        check16("async wr_drop", {15'd0, bus.wr_drop}, 16'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // sweep
        for (int r = 0; r < 15; r++) begin
            r4 = 4'(r);
            cyc(1'b1, r4, {16{r4}});
        end
        cyc(1'b0, 4'd0, '0);
        check16("sweep written", bus.written, 16'h7FFF);
        check64("sweep reg0", read_reg(bus.rd_slices, 0), 64'h0);
        check64("sweep reg5", read_reg(bus.rd_slices, 5), 64'h5555_5555_5555_5555);
        check64("sweep reg10", read_reg(bus.rd_slices, 10), 64'hAAAA_AAAA_AAAA_AAAA);
        for (int r = 0; r < 15; r++) begin
            r4 = 4'(r);
            pat = {16{r4}};
            check64($sformatf("sweep reg%0d", r), read_reg(bus.rd_slices, r), pat);
        end
        check64("sweep reg15", read_reg(bus.rd_slices, 15), 64'h0);

        // reset asserted in the same cycle as a write
        cyc(1'b1, 4'd5, 64'h0123_4567_89AB_CDEF);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.wr_en = 1'b0;
        cyc(1'b0, 4'd0, '0);
        check64("rstwr reg5", read_reg(bus.rd_slices, 5), 64'h0);
        check16("rstwr written", bus.written, 16'h0000);

        // first edge after release may write
        cyc(1'b1, 4'd9, 64'hFEDC_BA98_7654_3210);
        cyc(1'b0, 4'd0, '0);
        check64("post reg9", read_reg(bus.rd_slices, 9), 64'hFEDC_BA98_7654_3210);
        check16("post written", bus.written, 16'h0200);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
